// File: rtl/cluster_link_pkg.sv
// Shared types, constants and word builders for the cluster trigger-link formatter.
// Header layout: {comma, ovf, drop, cont[1:0], tag[3:0]}.
package cluster_link_pkg;

  localparam logic [7:0] COMMA        = 8'hBC;
  localparam int         CLUSTER_W    = 14;
  localparam int         NUM_CLUSTERS = 8;
  localparam int         HDR_OVF_BIT  = 7;
  localparam int         HDR_DROP_BIT = 6;
  localparam int         HDR_CONT_LSB = 4;
  localparam int         HDR_TAG_LSB  = 0;
  localparam logic [1:0] CONT_IDLE    = 2'b11;

  typedef logic [CLUSTER_W-1:0] cluster_t;

  typedef struct packed {
    cluster_t [NUM_CLUSTERS-1:0] clusters;
    logic                        ovf;
    logic [3:0]                  nvalid;
    logic [3:0]                  tag;
  } frame_entry_t;

  function automatic logic [15:0] make_header(input logic ovf, input logic drop,
                                              input logic [1:0] cont, input logic [3:0] tag);
    logic [15:0] h;
    h = '0;
    h[15:8] = COMMA;
    h[HDR_OVF_BIT] = ovf;
    h[HDR_DROP_BIT] = drop;
    h[HDR_CONT_LSB +: 2] = cont;
    h[HDR_TAG_LSB +: 4] = tag;
    return h;
  endfunction

  // Cluster index beyond the frame's valid count yields an all-zero filler word.
  function automatic logic [15:0] cluster_word(input frame_entry_t f, input logic [3:0] ci);
    logic [15:0] w;
    w = '0;
    if (ci < f.nvalid) begin
      w = {1'b1, (ci == f.nvalid - 4'd1), f.clusters[ci[2:0]]};
    end
    return w;
  endfunction

endpackage

// File: rtl/cluster_link_formatter_if.sv
// Frame input bus and trigger-link output bundle of the cluster link formatter.
interface cluster_link_formatter_if;

  logic        frame_valid;
  logic [13:0] cluster0, cluster1, cluster2, cluster3;
  logic [13:0] cluster4, cluster5, cluster6, cluster7;
  logic        overflow;
  logic [15:0] tx_data;
  logic        tx_k;
  logic        tx_frame_start;
  logic        fifo_full;
  logic [7:0]  frames_dropped;

  modport master (
    output frame_valid, cluster0, cluster1, cluster2, cluster3,
           cluster4, cluster5, cluster6, cluster7, overflow,
    input  tx_data, tx_k, tx_frame_start, fifo_full, frames_dropped
  );

  modport slave (
    input  frame_valid, cluster0, cluster1, cluster2, cluster3,
           cluster4, cluster5, cluster6, cluster7, overflow,
    output tx_data, tx_k, tx_frame_start, fifo_full, frames_dropped
  );

endinterface

// File: rtl/cluster_frame_fifo.sv
// First-word-fall-through frame FIFO on a register array; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module cluster_frame_fifo
  import cluster_link_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  frame_entry_t din,
  output frame_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  frame_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          full_reg, empty_reg;
  logic          do_push, do_pop;

  assign do_pop  = pop && !empty_reg;
  assign do_push = push && (!full_reg || do_pop);

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/cluster_link_formatter.sv
// Buffers 8-cluster frames and serializes them into 4-word link slots
// (comma header + three cluster words) at four clock4x cycles per slot.
module cluster_link_formatter
  import cluster_link_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [10:0] INVALID_ADR = 11'h7FE
) (
  input  logic                     clock4x,
  input  logic                     global_reset_n,
  cluster_link_formatter_if.slave  link
);

  cluster_t [NUM_CLUSTERS-1:0] clusters_in;
  logic [NUM_CLUSTERS-1:0]     valid_flag;
  logic [3:0]                  nvalid_in;
  logic                        run;

  assign clusters_in = {link.cluster7, link.cluster6, link.cluster5, link.cluster4,
                        link.cluster3, link.cluster2, link.cluster1, link.cluster0};

  for (genvar gi = 0; gi < NUM_CLUSTERS; gi++) begin : g_valid
    assign valid_flag[gi] = (clusters_in[gi][10:0] != INVALID_ADR);
  end

  // Only the leading run of valid clusters counts.
  always_comb begin
    nvalid_in = '0;
    run = 1'b1;
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      if (!valid_flag[i]) run = 1'b0;
      if (run) nvalid_in = nvalid_in + 4'd1;
    end
  end

  logic [1:0]        phase_reg, seg_reg, seg_next;
  logic [3:0]        tag_reg, base;
  logic              drop_pend_reg;
  logic [7:0]        dropped_reg;
  logic [3:0][15:0]  slot_reg, slot_next;
  logic [15:0]       tx_data_reg;
  logic              tx_k_reg, tx_frame_start_reg;
  logic              latch, keep, accept, drop;
  logic              fifo_pop, fifo_full, fifo_empty;
  frame_entry_t      fifo_din, head;

  assign latch  = (phase_reg == 2'd3);
  assign keep   = link.frame_valid && ((nvalid_in != 4'd0) || link.overflow);
  assign accept = keep && (!fifo_full || fifo_pop);
  assign drop   = keep && !accept;

  assign fifo_din = '{clusters: clusters_in, ovf: link.overflow, nvalid: nvalid_in, tag: tag_reg};

  cluster_frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clock4x),
    .rst_n (global_reset_n),
    .push  (accept),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next slot from the FIFO head; seg_reg selects which group of three clusters.
  always_comb begin
    slot_next = '0;
    fifo_pop  = 1'b0;
    seg_next  = seg_reg;
    base      = 4'(seg_reg) * 4'd3;
    slot_next[0] = make_header(1'b0, drop_pend_reg, CONT_IDLE, 4'h0);
    if (!fifo_empty) begin
      slot_next[0] = make_header(head.ovf, drop_pend_reg, seg_reg, head.tag);
      slot_next[1] = cluster_word(head, base);
      slot_next[2] = cluster_word(head, base + 4'd1);
      slot_next[3] = cluster_word(head, base + 4'd2);
      if (base + 4'd3 >= head.nvalid) begin
        fifo_pop = latch;
        seg_next = 2'd0;
      end else begin
        seg_next = seg_reg + 2'd1;
      end
    end
  end

  always_ff @(posedge clock4x) begin
    if (!global_reset_n) begin
      phase_reg          <= 2'd0;
      seg_reg            <= 2'd0;
      tag_reg            <= 4'd0;
      drop_pend_reg      <= 1'b0;
      dropped_reg        <= 8'd0;
      slot_reg           <= {48'h0, make_header(1'b0, 1'b0, CONT_IDLE, 4'h0)};
      tx_data_reg        <= 16'h0;
      tx_k_reg           <= 1'b0;
      tx_frame_start_reg <= 1'b0;
    end else begin
      phase_reg <= phase_reg + 2'd1;
      if (accept) tag_reg <= tag_reg + 4'd1;
      // A drop coinciding with the latch must survive into the following header.
      if (drop) drop_pend_reg <= 1'b1;
      else if (latch) drop_pend_reg <= 1'b0;
      if (drop && (dropped_reg != 8'hFF)) dropped_reg <= dropped_reg + 8'd1;
      if (latch) begin
        slot_reg <= slot_next;
        seg_reg  <= seg_next;
      end
      tx_data_reg        <= latch ? slot_next[0] : slot_reg[phase_reg + 2'd1];
      tx_k_reg           <= latch;
      tx_frame_start_reg <= latch;
    end
  end

  assign link.tx_data        = tx_data_reg;
  assign link.tx_k           = tx_k_reg;
  assign link.tx_frame_start = tx_frame_start_reg;
  assign link.fifo_full      = fifo_full;
  assign link.frames_dropped = dropped_reg;

endmodule
